// File: rtl/pll_reset_sequencer.sv
// PLL power-up / lock-recovery sequencer with staggered per-domain reset release.
// Optional: define PLL_SEQ_LOSS_COUNT_EN to add the lock_loss_count output.
module pll_reset_sequencer #(
    parameter int NUM_DOMAINS    = 6,
    parameter int RESET_CYCLES   = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 256,
    parameter int STAGGER_CYCLES = 8,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   restart,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   ready,
    output logic                   fault,
    output logic [7:0]             retry_count
`ifdef PLL_SEQ_LOSS_COUNT_EN
    ,
    output logic [7:0]             lock_loss_count
`endif
);

    localparam int REL_SPAN = (NUM_DOMAINS - 1) * STAGGER_CYCLES + 1;
    localparam int MAX_AB   = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD   = (STABLE_CYCLES > REL_SPAN) ? STABLE_CYCLES : REL_SPAN;
    localparam int CNT_MAX  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST  = CW'(REL_SPAN - 1);
    localparam logic [7:0]    RETRY_MAX = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_HOLD,
        WAIT_LOCK,
        STABILIZE,
        RELEASE,
        RUN,
        FAULT
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [1:0]             sync_q;
    logic                   locked_s;
    logic                   lock_lost;
    logic [NUM_DOMAINS-1:0] rst_out_d;
    logic                   ready_d;
    logic [7:0]             retry_d;

    assign locked_s  = sync_q[1];
    assign lock_lost = !locked_s && (state_q == RELEASE || state_q == RUN);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_out_d = rst_out;
        ready_d   = ready;
        retry_d   = retry_count;
        if (restart) begin
            state_d   = RESET_HOLD;
            cnt_d     = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
            retry_d   = '0;
        end else if (lock_lost) begin
            state_d   = RESET_HOLD;
            cnt_d     = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
        end else begin
            unique case (state_q)
                RESET_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABILIZE;
                        cnt_d   = '0;
                    end else if (cnt_q == WAIT_LAST) begin
                        cnt_d = '0;
                        if (retry_count == RETRY_MAX) begin
                            state_d = FAULT;
                        end else begin
                            state_d = RESET_HOLD;
                            retry_d = retry_count + 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STABILIZE: begin
                    // A single low sample restarts the whole lock wait.
                    if (!locked_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STAB_LAST) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RELEASE: begin
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (cnt_q == CW'(i * STAGGER_CYCLES)) begin
                            rst_out_d[i] = 1'b0;
                        end
                    end
                    if (cnt_q == REL_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RUN: begin
                end
                FAULT: begin
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                end
                default: begin
                    state_d = RESET_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= RESET_HOLD;
            cnt_q       <= '0;
            sync_q      <= '0;
            pll_rst     <= 1'b1;
            rst_out     <= '1;
            ready       <= 1'b0;
            fault       <= 1'b0;
            retry_count <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= {sync_q[0], pll_locked};
            pll_rst     <= (state_d == RESET_HOLD) || (state_d == FAULT);
            rst_out     <= rst_out_d;
            ready       <= ready_d;
            fault       <= (state_d == FAULT);
            retry_count <= retry_d;
        end
    end

`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_cnt_q;

    // A restart in the same cycle takes precedence and is not a lock loss.
    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_cnt_q <= '0;
        end else if (lock_lost && !restart && loss_cnt_q != 8'hFF) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_count = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: phase/duration reference model,
// per-scenario tasks plus a randomized soak.
module tb_pll_reset_sequencer;

    localparam int N   = 6;
    localparam int RC  = 4;
    localparam int LT  = 32;
    localparam int SC  = 8;
    localparam int SS  = 2;
    localparam int MR  = 2;
    localparam int REL_LEN = (N - 1) * SS + 1;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    localparam int VW = N + 19;
`else
    localparam int VW = N + 11;
`endif

    localparam int P_HOLD  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_STAB  = 2;
    localparam int P_REL   = 3;
    localparam int P_RUN   = 4;
    localparam int P_FAULT = 5;

    logic         refclk = 1'b0;
    logic         rst = 1'b1;
    logic         pll_locked = 1'b0;
    logic         restart = 1'b0;
    logic         pll_rst;
    logic [N-1:0] rst_out;
    logic         ready;
    logic         fault;
    logic [7:0]   retry_count;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic [7:0]   lock_loss_count;
`endif

    int checks = 0;
    int failures = 0;

    int ph = P_HOLD;
    int t = 0;
    int m_retry = 0;
    int m_llc = 0;
    bit q[$];

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .NUM_DOMAINS(N),
        .RESET_CYCLES(RC),
        .LOCK_TIMEOUT(LT),
        .STABLE_CYCLES(SC),
        .STAGGER_CYCLES(SS),
        .MAX_RETRIES(MR)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .restart(restart),
        .pll_rst(pll_rst),
        .rst_out(rst_out),
        .ready(ready),
        .fault(fault),
        .retry_count(retry_count)
`ifdef PLL_SEQ_LOSS_COUNT_EN
        ,
        .lock_loss_count(lock_loss_count)
`endif
    );

    // Reference model: phase + time spent in phase; lock seen 2 edges late.
    task automatic tick();
        bit ls;
        @(posedge refclk);
        if (rst) begin
            ph = P_HOLD;
            t = 0;
            m_retry = 0;
            m_llc = 0;
            q.delete();
            q.push_back(1'b0);
            q.push_back(1'b0);
        end else begin
            ls = q.pop_front();
            q.push_back(pll_locked);
            if (restart) begin
                ph = P_HOLD;
                t = 0;
                m_retry = 0;
            end else if ((ph == P_REL || ph == P_RUN) && !ls) begin
                ph = P_HOLD;
                t = 0;
                if (m_llc < 255) m_llc++;
            end else begin
                case (ph)
                    P_HOLD: begin
                        t++;
                        if (t == RC) begin ph = P_WAIT; t = 0; end
                    end
                    P_WAIT: begin
                        if (ls) begin
                            ph = P_STAB;
                            t = 0;
                        end else begin
                            t++;
                            if (t == LT) begin
                                t = 0;
                                if (m_retry == MR) ph = P_FAULT;
                                else begin m_retry++; ph = P_HOLD; end
                            end
                        end
                    end
                    P_STAB: begin
                        if (!ls) begin
                            ph = P_WAIT;
                            t = 0;
                        end else begin
                            t++;
                            if (t == SC) begin ph = P_REL; t = 0; end
                        end
                    end
                    P_REL: begin
                        t++;
                        if (t == REL_LEN) begin ph = P_RUN; t = 0; m_retry = 0; end
                    end
                    default: ;
                endcase
            end
        end
        #1;
    endtask

    function automatic logic [N-1:0] m_rst_out();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++)
            r[i] = !(ph == P_RUN || (ph == P_REL && t >= i * SS + 1));
        return r;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic e_prst, e_rdy, e_flt;
        e_prst = (ph == P_HOLD) || (ph == P_FAULT);
        e_rdy  = (ph == P_RUN);
        e_flt  = (ph == P_FAULT);
`ifdef PLL_SEQ_LOSS_COUNT_EN
        return {e_prst, m_rst_out(), e_rdy, e_flt, 8'(m_retry), 8'(m_llc)};
`else
        return {e_prst, m_rst_out(), e_rdy, e_flt, 8'(m_retry)};
`endif
    endfunction

    function automatic logic [VW-1:0] act_vec();
`ifdef PLL_SEQ_LOSS_COUNT_EN
        return {pll_rst, rst_out, ready, fault, retry_count, lock_loss_count};
`else
        return {pll_rst, rst_out, ready, fault, retry_count};
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        restart = 1'b0;
        pll_locked = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        restart = 1'b0;
        pll_locked = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_model got=%h want=%h", act_vec(), exp_vec());
            end
        end
        checks++;
        if ({pll_rst, rst_out, ready, fault, retry_count} !== {1'b1, {N{1'b1}}, 10'd0}) begin
            failures++;
            $display("FAIL reset_values got=%b/%b/%b/%b/%0d want=1/111111/0/0/0",
                     pll_rst, rst_out, ready, fault, retry_count);
        end
        rst = 1'b0;
        pll_locked = 1'b0;
    endtask

    task automatic test_bringup();
        int hi;
        int rdy_at;
        int fall[N];
        logic [N-1:0] prev;
        rst = 1'b1;
        restart = 1'b0;
        pll_locked = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        hi = pll_rst ? 1 : 0;
        rdy_at = -1;
        prev = rst_out;
        for (int i = 0; i < N; i++) fall[i] = -1;
        for (int c = 0; c < 80; c++) begin
            if (c == 10) pll_locked = 1'b1;
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                if (failures <= 20)
                    $display("FAIL bringup c=%0d got=%h want=%h", c, act_vec(), exp_vec());
            end
            if (pll_rst) hi++;
            for (int i = 0; i < N; i++)
                if (prev[i] && !rst_out[i]) fall[i] = c;
            if (ready && rdy_at < 0) rdy_at = c;
            prev = rst_out;
        end
        checks++;
        if (hi != RC) begin
            failures++;
            $display("FAIL bringup_pll_rst_len got=%0d want=%0d", hi, RC);
        end
        checks++;
        if (fall[0] < 0) begin
            failures++;
            $display("FAIL bringup_bit0_fall got=%0d want=>=0", fall[0]);
        end
        for (int i = 1; i < N; i++) begin
            checks++;
            if (fall[i] - fall[i-1] != SS) begin
                failures++;
                $display("FAIL bringup_stagger%0d got=%0d want=%0d", i, fall[i] - fall[i-1], SS);
            end
        end
        checks++;
        if (rdy_at != fall[N-1] || rdy_at < 0 || retry_count !== 8'd0) begin
            failures++;
            $display("FAIL bringup_ready got=%0d/%0d want=%0d/0", rdy_at, retry_count, fall[N-1]);
        end
    endtask

    task automatic test_timeouts();
        int low;
        int seen[$];
        logic [7:0] last;
        do_reset();
        low = 0;
        last = retry_count;
        for (int c = 0; c < 300 && !fault; c++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                if (failures <= 20)
                    $display("FAIL timeout c=%0d got=%h want=%h", c, act_vec(), exp_vec());
            end
            if (!pll_rst) low++;
            if (retry_count != last) begin
                seen.push_back(int'(retry_count));
                last = retry_count;
            end
        end
        checks++;
        if (fault !== 1'b1 || pll_rst !== 1'b1) begin
            failures++;
            $display("FAIL timeout_fault got=%b/%b want=1/1", fault, pll_rst);
        end
        checks++;
        if (low != 3 * LT) begin
            failures++;
            $display("FAIL timeout_windows got=%0d want=%0d", low, 3 * LT);
        end
        checks++;
        if (seen.size() != 2 || seen[0] != 1 || seen[1] != 2) begin
            failures++;
            $display("FAIL timeout_retry_seq got_n=%0d want=1,2", seen.size());
        end
        repeat (5) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL fault_hold got=%h want=%h", act_vec(), exp_vec());
            end
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++;
        if (fault !== 1'b0 || retry_count !== 8'd0 || pll_rst !== 1'b1) begin
            failures++;
            $display("FAIL fault_exit got=%b/%0d/%b want=0/0/1", fault, retry_count, pll_rst);
        end
        pll_locked = 1'b1;
        for (int c = 0; c < 100 && !ready; c++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                if (failures <= 20)
                    $display("FAIL fault_rebring c=%0d got=%h want=%h", c, act_vec(), exp_vec());
            end
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL fault_rebring_ready got=%b want=1", ready);
        end
    endtask

    task automatic test_glitch();
        int k;
        int n;
        for (int it = 0; it < 3; it++) begin
            k = (it == 0) ? 5 : int'($urandom_range(1, 6));
            do_reset();
            for (int c = 0; c < 20 && ph != P_WAIT; c++) tick();
            pll_locked = 1'b1;
            repeat (k) tick();
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
            n = 0;
            for (int c = 0; c < 40; c++) begin
                tick();
                n++;
                checks++;
                if (act_vec() !== exp_vec()) begin
                    failures++;
                    if (failures <= 20)
                        $display("FAIL glitch k=%0d got=%h want=%h", k, act_vec(), exp_vec());
                end
                if (!rst_out[0]) break;
            end
            checks++;
            if (n != 12 || retry_count !== 8'd0) begin
                failures++;
                $display("FAIL glitch_delay k=%0d got=%0d/%0d want=12/0", k, n, retry_count);
            end
        end
    endtask

    task automatic test_run_loss();
        int n;
        int hi;
        do_reset();
        pll_locked = 1'b1;
        for (int c = 0; c < 100 && !ready; c++) tick();
        repeat (3) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        n = 1;
        for (int c = 0; c < 10 && !(rst_out == '1 && !ready); c++) begin
            tick();
            n++;
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL runloss c=%0d got=%h want=%h", c, act_vec(), exp_vec());
            end
        end
        checks++;
        if (n != 3 || rst_out !== '1 || ready !== 1'b0) begin
            failures++;
            $display("FAIL runloss_latency got=%0d want=3", n);
        end
        hi = 0;
        for (int c = 0; c < 100 && !ready; c++) begin
            tick();
            if (pll_rst) hi++;
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                if (failures <= 20)
                    $display("FAIL runloss_rebring got=%h want=%h", act_vec(), exp_vec());
            end
        end
        checks++;
        if (hi != RC - 1 || ready !== 1'b1) begin
            failures++;
            $display("FAIL runloss_pll_rst got=%0d/%b want=%0d/1", hi + 1, ready, RC);
        end
`ifdef PLL_SEQ_LOSS_COUNT_EN
        checks++;
        if (lock_loss_count !== 8'd1) begin
            failures++;
            $display("FAIL runloss_count got=%0d want=1", lock_loss_count);
        end
`endif
    endtask

    task automatic test_abort_mid_release();
        do_reset();
        pll_locked = 1'b1;
        for (int c = 0; c < 100 && rst_out[1] !== 1'b0; c++) tick();
        tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        checks++;
        if (rst_out !== 6'b111000) begin
            failures++;
            $display("FAIL abort_partial got=%b want=111000", rst_out);
        end
        tick();
        checks++;
        if (rst_out !== 6'b111000) begin
            failures++;
            $display("FAIL abort_hold got=%b want=111000", rst_out);
        end
        tick();
        checks++;
        if (rst_out !== 6'b111111 || pll_rst !== 1'b1 || ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_reassert got=%b/%b want=111111/1", rst_out, pll_rst);
        end
        for (int c = 0; c < 100 && !ready; c++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                if (failures <= 20)
                    $display("FAIL abort_rebring got=%h want=%h", act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_restart_vs_timeout();
        do_reset();
        for (int c = 0; c < 200; c++) begin
            if (ph == P_WAIT && t == LT - 1 && m_retry == 1) break;
            tick();
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++;
        if (retry_count !== 8'd0 || fault !== 1'b0 || pll_rst !== 1'b1) begin
            failures++;
            $display("FAIL restart_timeout got=%0d/%b/%b want=0/0/1", retry_count, fault, pll_rst);
        end
        repeat (10) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL restart_after got=%h want=%h", act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
            restart = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                if (failures <= 20)
                    $display("FAIL random c=%0d got=%h want=%h", c, act_vec(), exp_vec());
            end
        end
        restart = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_timeouts();
        test_glitch();
        test_run_loss();
        test_abort_mid_release();
        test_restart_vs_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
